// File: rtl/irq_pkg.sv
// irq_pkg: shared FSM state type and default sizing for the interrupt controller
package irq_pkg;
    localparam int NSRC_DEF = 8;
    localparam int ID_W_DEF = 3;
    typedef enum logic [1:0] {IDLE, TAKE, SERVICE} state_t;
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: fixed-priority encoder, lowest set index wins
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int N = NSRC_DEF,
    parameter int W = ID_W_DEF
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [W-1:0] id
);
    always_comb begin
        valid = |req;
        id = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[i]) id = W'(i);
    end
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-triggered, maskable, fixed-priority interrupt controller with a non-nesting trap FSM
// Define IRQ_SYNC_EN to pass irq_src through a two-flop synchronizer (+2 cycles latency).
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int NSRC = NSRC_DEF,
    parameter int ID_W = ID_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_src,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_wdata,
    input  logic            ecall,
    input  logic            ill_inst,
    input  logic            mret,
    output logic            interrupt,
    output logic [ID_W-1:0] irq_id,
    output logic            in_service,
    output logic [NSRC-1:0] pending,
    output logic [NSRC-1:0] mask
);
    logic [NSRC-1:0] cond, prev, edge_v, clr, req;
    logic            win_valid, busy;
    logic [ID_W-1:0] win_id;
    state_t          state, nxt;

`ifdef IRQ_SYNC_EN
    localparam int ARM_N = 3;
    logic [NSRC-1:0] s1, s2;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= irq_src;
            s2 <= s1;
        end
    assign cond = s2;
`else
    localparam int ARM_N = 1;
    assign cond = irq_src;
`endif

    // Edges stay disarmed until prev holds a genuine post-reset sample,
    // so a source held high across reset never looks like a rising edge.
    logic [ARM_N-1:0] arm;
    assign edge_v = cond & ~prev & {NSRC{arm[ARM_N-1]}};
    assign req    = pending & mask;
    assign busy   = ecall | ill_inst | mret;

    irq_prio_enc #(.N(NSRC), .W(ID_W)) u_prio (
        .req  (req),
        .valid(win_valid),
        .id   (win_id)
    );

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = (win_valid && !busy) ? TAKE : IDLE;
            TAKE:    nxt = busy ? TAKE : SERVICE;
            SERVICE: nxt = mret ? IDLE : SERVICE;
            default: nxt = IDLE;
        endcase
    end

    assign clr        = (state == TAKE && !busy) ? (NSRC'(1) << irq_id) : '0;
    assign interrupt  = state == TAKE;
    assign in_service = state == SERVICE;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= IDLE;
            prev    <= '0;
            arm     <= '0;
            pending <= '0;
            mask    <= '0;
            irq_id  <= '0;
        end else begin
            state   <= nxt;
            prev    <= cond;
            arm     <= ARM_N'({arm, 1'b1});
            pending <= (pending & ~clr) | edge_v;
            if (mask_we) mask <= mask_wdata;
            if (state == IDLE && nxt == TAKE) irq_id <= win_id;
        end
endmodule
